// File: rtl/named_decode_if.sv
// Handshake bundle between the named-offset decoder and its neighbours.
// master drives beats in and takes decoded beats out; slave is the decoder.
interface named_decode_if #(
  parameter int NX = 8
);
  logic          SYNC;
  logic          IN_VALID;
  logic          IN_READY;
  logic [NX-1:0] DIN;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [NX-1:0] DOUT;
  logic [NX-1:0] CNT;

  modport master (
    output SYNC, IN_VALID, DIN, OUT_READY,
    input  IN_READY, OUT_VALID, DOUT, CNT
  );

  modport slave (
    input  SYNC, IN_VALID, DIN, OUT_READY,
    output IN_READY, OUT_VALID, DOUT, CNT
  );
endinterface

// File: rtl/named_decode.sv
// Adds the running offset back onto each encoded beat; 1-cycle latency, full throughput.
// Backpressure: one-entry skid absorbs the first stalled beat, IN_READY drops while it is full.
module named_decode #(
  parameter int NX   = 8,
  parameter int STEP = 1,
  parameter int INIT = 0
) (
  input  logic           CLK,
  input  logic           RST,
  named_decode_if.slave  io
);
  localparam logic [NX-1:0] STEP_W = NX'(STEP);
  localparam logic [NX-1:0] INIT_W = NX'(INIT);

  logic [NX-1:0] cnt_q, cnt_d;
  logic          out_vld_q, out_vld_d;
  logic [NX-1:0] dout_q, dout_d;
  logic          skid_full_q, skid_full_d;
  logic [NX-1:0] skid_dat_q, skid_dat_d;
  logic          in_rdy_q, in_rdy_d;

  logic          in_acc;
  logic          out_free;
  logic [NX-1:0] base;
  logic [NX-1:0] dec;

  always_comb begin
    in_acc   = io.IN_VALID & in_rdy_q;
    out_free = !out_vld_q | io.OUT_READY;
    // SYNC in the same cycle as an accept makes that beat index 0 of the new run
    base     = io.SYNC ? INIT_W : cnt_q;
    dec      = io.DIN + base + STEP_W;

    cnt_d = cnt_q;
    if (in_acc) begin
      cnt_d = base + STEP_W;
    end else if (io.SYNC) begin
      cnt_d = INIT_W;
    end

    out_vld_d   = out_vld_q;
    dout_d      = dout_q;
    skid_full_d = skid_full_q;
    skid_dat_d  = skid_dat_q;

    if (out_free) begin
      if (skid_full_q) begin
        out_vld_d   = 1'b1;
        dout_d      = skid_dat_q;
        skid_full_d = 1'b0;
        // unreachable while IN_READY mirrors !skid_full, kept so no beat can ever drop
        if (in_acc) begin
          skid_dat_d  = dec;
          skid_full_d = 1'b1;
        end
      end else if (in_acc) begin
        out_vld_d = 1'b1;
        dout_d    = dec;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (in_acc) begin
      skid_dat_d  = dec;
      skid_full_d = 1'b1;
    end

    in_rdy_d = !skid_full_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q       <= INIT_W;
      out_vld_q   <= 1'b0;
      dout_q      <= '0;
      skid_full_q <= 1'b0;
      skid_dat_q  <= '0;
      in_rdy_q    <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      out_vld_q   <= out_vld_d;
      dout_q      <= dout_d;
      skid_full_q <= skid_full_d;
      skid_dat_q  <= skid_dat_d;
      in_rdy_q    <= in_rdy_d;
    end
  end

  assign io.IN_READY  = in_rdy_q;
  assign io.OUT_VALID = out_vld_q;
  assign io.DOUT      = dout_q;
  assign io.CNT       = cnt_q;
endmodule

// File: tb/tb_named_decode.sv
// Directed bench for named_decode: default instance plus a STEP=3/INIT=0xFE instance.
module tb_named_decode;
  logic CLK;
  logic RST;
  int   total;
  int   bad;

  named_decode_if #(.NX(8)) a_if ();
  named_decode_if #(.NX(8)) b_if ();

  named_decode #(.NX(8), .STEP(1), .INIT(0)) u_def (
    .CLK (CLK),
    .RST (RST),
    .io  (a_if.slave)
  );

  named_decode #(.NX(8), .STEP(3), .INIT(254)) u_alt (
    .CLK (CLK),
    .RST (RST),
    .io  (b_if.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // outputs are sampled 1 ns after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #2;
    RST = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST   = 1'b1;
    a_if.SYNC = 1'b0; a_if.IN_VALID = 1'b0; a_if.DIN = 8'h00; a_if.OUT_READY = 1'b0;
    b_if.SYNC = 1'b0; b_if.IN_VALID = 1'b0; b_if.DIN = 8'h00; b_if.OUT_READY = 1'b0;
    #12;
    RST = 1'b0;

    check("rst_out_valid", a_if.OUT_VALID, 1'b0);
    check("rst_dout",      a_if.DOUT,      8'h00);
    check("rst_in_ready",  a_if.IN_READY,  1'b1);
    check("rst_cnt",       a_if.CNT,       8'h00);
    check("rst_cnt_alt",   b_if.CNT,       8'hFE);

    // basic stream
    tick();
    a_if.OUT_READY = 1'b1;
    a_if.IN_VALID  = 1'b1;
    a_if.DIN       = 8'hFE;
    tick();
    check("basic_vld0", a_if.OUT_VALID, 1'b1);
    check("basic_d0",   a_if.DOUT,      8'hFF);
    a_if.DIN = 8'h05;
    tick();
    check("basic_d1",   a_if.DOUT,      8'h07);
    a_if.DIN = 8'h00;
    tick();
    check("basic_d2",   a_if.DOUT,      8'h03);
    check("basic_cnt",  a_if.CNT,       8'h03);
    a_if.IN_VALID = 1'b0;
    tick();
    check("basic_idle", a_if.OUT_VALID, 1'b0);
    check("basic_hold", a_if.DOUT,      8'h03);

    // counter wrap over 256 beats
    do_reset();
    tick();
    a_if.IN_VALID = 1'b1;
    a_if.DIN      = 8'h00;
    for (int i = 0; i < 256; i++) begin
      tick();
      check("wrap_dout", a_if.DOUT, 32'((i + 1) & 8'hFF));
    end
    a_if.IN_VALID = 1'b0;
    check("wrap_cnt", a_if.CNT, 8'h00);
    tick();

    // backpressure and skid
    do_reset();
    tick();
    a_if.OUT_READY = 1'b0;
    a_if.IN_VALID  = 1'b1;
    a_if.DIN       = 8'h10;
    tick();
    check("bp_d0",     a_if.DOUT,     8'h11);
    check("bp_rdy0",   a_if.IN_READY, 1'b1);
    a_if.DIN = 8'h20;
    tick();
    check("bp_rdy1",   a_if.IN_READY, 1'b0);
    check("bp_stable1", a_if.DOUT,    8'h11);
    a_if.DIN = 8'h30;
    tick();
    tick();
    check("bp_stable2", a_if.DOUT,    8'h11);
    check("bp_vld",     a_if.OUT_VALID, 1'b1);
    check("bp_rdy2",    a_if.IN_READY, 1'b0);
    check("bp_cnt",     a_if.CNT,      8'h02);
    a_if.OUT_READY = 1'b1;
    tick();
    check("bp_rel0",   a_if.DOUT,      8'h22);
    check("bp_rel0v",  a_if.OUT_VALID, 1'b1);
    check("bp_rdy3",   a_if.IN_READY,  1'b1);
    tick();
    check("bp_rel1",   a_if.DOUT,      8'h33);
    check("bp_rel1v",  a_if.OUT_VALID, 1'b1);
    a_if.IN_VALID = 1'b0;
    tick();
    check("bp_drain",  a_if.OUT_VALID, 1'b0);

    // SYNC together with an accept while a beat sits in the output register
    do_reset();
    tick();
    a_if.OUT_READY = 1'b1;
    a_if.IN_VALID  = 1'b1;
    a_if.DIN       = 8'h00;
    repeat (5) tick();
    check("sync_pre_cnt",  a_if.CNT,  8'h05);
    check("sync_pre_dout", a_if.DOUT, 8'h05);
    a_if.OUT_READY = 1'b0;
    a_if.DIN       = 8'h40;
    a_if.SYNC      = 1'b1;
    tick();
    a_if.SYNC     = 1'b0;
    a_if.IN_VALID = 1'b0;
    check("sync_cnt",   a_if.CNT,  8'h01);
    check("sync_held",  a_if.DOUT, 8'h05);
    a_if.OUT_READY = 1'b1;
    tick();
    check("sync_dout",  a_if.DOUT,      8'h41);
    check("sync_vld",   a_if.OUT_VALID, 1'b1);
    tick();

    // async reset while output and skid are both full
    do_reset();
    tick();
    a_if.OUT_READY = 1'b0;
    a_if.IN_VALID  = 1'b1;
    a_if.DIN       = 8'h50;
    tick();
    a_if.DIN = 8'h60;
    tick();
    a_if.IN_VALID = 1'b0;
    check("ar_pre_rdy", a_if.IN_READY, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    check("ar_vld",  a_if.OUT_VALID, 1'b0);
    check("ar_dout", a_if.DOUT,      8'h00);
    check("ar_rdy",  a_if.IN_READY,  1'b1);
    check("ar_cnt",  a_if.CNT,       8'h00);
    #1;
    RST = 1'b0;
    a_if.OUT_READY = 1'b1;
    tick();
    check("ar_after", a_if.OUT_VALID, 1'b0);

    // STEP=3, INIT=0xFE instance
    check("alt_rst_cnt", b_if.CNT, 8'hFE);
    b_if.OUT_READY = 1'b1;
    b_if.IN_VALID  = 1'b1;
    b_if.DIN       = 8'h00;
    tick();
    check("alt_d0",  b_if.DOUT, 8'h01);
    check("alt_c0",  b_if.CNT,  8'h01);
    tick();
    b_if.IN_VALID = 1'b0;
    check("alt_d1",  b_if.DOUT, 8'h04);
    check("alt_cnt", b_if.CNT,  8'h04);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/named_decode.md
# named_decode

Receive-side counterpart of the named-offset encoder. The encoder emits, for each beat n (0-based since reset or resync), `Y_n = S_n - (INIT + STEP*(n+1)) mod 2^NX`, where `S_n` is the original sum. This block accepts that stream over a valid/ready handshake, adds back its own running offset to recover `S_n`, and presents the result through a registered, full-throughput output stage with a one-entry skid buffer. It sits directly downstream of the encoder in the datapath.

## Interface
Parameters:
- `NX`, default 8: data and counter width in bits.
- `STEP`, default 1: offset increment per accepted beat; taken mod 2^NX.
- `INIT`, default 0: counter value after reset or `SYNC`; taken mod 2^NX.

Ports (one clock; reset is asynchronous and active-high):
- `CLK`  input  1  clock; all state changes on the rising edge.
- `RST`  input  1  asynchronous, active-high reset.
- `SYNC`  input  1  synchronous counter restart to `INIT`.
- `IN_VALID`  input  1  `DIN` carries a beat.
- `IN_READY`  output  1  block can accept a beat; registered.
- `DIN`  input  NX  encoded value `Y_n`.
- `OUT_VALID`  output  1  `DOUT` holds a decoded beat.
- `OUT_READY`  input  1  downstream accepts `DOUT`.
- `DOUT`  output  NX  decoded value `S_n`.
- `CNT`  output  NX  current offset counter value, for debug and verification.

## Operation
- State:
  - offset counter `cnt`;
  - output register: `OUT_VALID`, `DOUT`;
  - skid register: `skid_full`, `skid_data`.
- Beats:
  - An input accept is `IN_VALID & IN_READY`.
  - An output accept is `OUT_VALID & OUT_READY`.
- Offset for an accepted beat:
  - Let `base` = `INIT` if `SYNC` is high in the same cycle, else `cnt`.
  - Decoded value = `DIN + base + STEP`, mod 2^NX (wrap, no saturation, no carry out).
  - Next `cnt` = `base + STEP`.
- `SYNC` with no accept: `cnt` <= `INIT`.
- `SYNC` never flushes beats already held in the output or skid registers.
- No accept and no `SYNC`: `cnt` holds.
- Output register load rule, applied when it is empty or an output accept occurs:
  - if `skid_full`, load `skid_data` and clear `skid_full`;
  - else if an input accept occurs, load the decoded value;
  - else clear `OUT_VALID`.
- Skid load rule: an input accept while the output register is full and not accepted writes the decoded value into the skid and sets `skid_full`.
- `IN_READY` <= `!skid_full_next`. It deasserts the cycle after the skid fills and reasserts the cycle after it drains.
- Ordering: beats leave in acceptance order; none are dropped or duplicated.
- `DOUT` and `skid_data` hold their values while not being loaded.

## Timing
- Reset values (asynchronous): `cnt`=`INIT`, `CNT`=`INIT`, `OUT_VALID`=0, `DOUT`=0, `skid_full`=0, `IN_READY`=1.
- Reset asserted mid-transfer discards both held beats immediately. No output accept is reported while `RST` is high.
- Latency: a beat accepted at edge k appears on `DOUT` with `OUT_VALID`=1 after edge k if the output register is free.
- Throughput: one beat per cycle with `OUT_READY` held high.
- Backpressure:
  - The first stalled cycle absorbs one extra beat into the skid.
  - Maximum occupancy is 2 beats.
- The block never accepts a beat while `skid_full`=1.
- `DOUT`/`OUT_VALID` must stay stable while `OUT_VALID`=1 and `OUT_READY`=0.
- Counter wrap: after 2^NX accepts with `STEP`=1 and no `SYNC`, `cnt` returns to `INIT` with no special handling.
- Simultaneous accept and `SYNC`: the accepted beat is index 0 of the new sequence (see Operation).

## Test plan
- Defaults, `OUT_READY`=1. Drive `DIN` = 0xFE, 0x05, 0x00 on consecutive cycles. Required: `DOUT` = 0xFF, 0x07, 0x03, each one cycle after its accept; `CNT` ends at 3.
- Wrap: feed 256 beats of `DIN`=0x00. Required: `DOUT` sequence 0x01…0xFF then 0x00; `CNT` back to 0x00.
- Backpressure:
  - Stream 0x10, 0x20, 0x30 with `OUT_READY`=0 from the first accept. Required: two beats held, `IN_READY`=0, third beat stalled, `DOUT`=0x11 stable.
  - Release `OUT_READY`. Required: 0x11, 0x22, 0x33 in order, no gaps after release.
- `SYNC` coinciding with an accept of `DIN`=0x40 while `CNT`=0x05. Required: `DOUT`=0x41, `CNT`=0x01. A beat already in the output register is delivered unchanged.
- Reset asserted asynchronously while both registers are full. Required: `OUT_VALID`=0, `DOUT`=0, `IN_READY`=1, `CNT`=`INIT` immediately, without a clock edge.
- `STEP`=3, `INIT`=0xFE. Drive `DIN`=0x00 twice. Required: `DOUT`=0x01 then 0x04; `CNT`=0x04.
